// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and helpers for the register write arbiter.
// Grant-id width stays at least one bit for any requester count.
package reg_write_arbiter_pkg;

  localparam int unsigned def_width   = 32;
  localparam int unsigned def_els     = 8;
  localparam int unsigned def_num_req = 2;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Multi-requester write bus: packed per-requester slices plus grant.
// Slice k of each vector belongs to requester k.
interface reg_write_arbiter_if #(
  parameter int width_p   = 32,
  parameter int addr_w    = 3,
  parameter int num_req_p = 2
);

  logic [num_req_p-1:0]         req_v_i;
  logic [num_req_p*addr_w-1:0]  req_addr_i;
  logic [num_req_p*width_p-1:0] req_data_i;
  logic [num_req_p-1:0]         req_ready_o;

  modport master (
    output req_v_i,
    output req_addr_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_v_i,
    input  req_addr_i,
    input  req_data_i,
    output req_ready_o
  );

endinterface

// File: rtl/dff.sv
// Enable-gated register with synchronous active-high reset.
module dff #(
  parameter int              width_p     = 32,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               w_v_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      data_o <= reset_val_p;
    else if (w_v_i)
      data_o <= data_i;
  end

endmodule

// File: rtl/reg_write_arbiter_rr_arb.sv
// Round-robin arbiter: scan starts one past the last granted index.
module rr_arb
  import reg_write_arbiter_pkg::*;
#(
  parameter int num_req_p = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [num_req_p-1:0]             v_i,
  input  logic                             yumi_i,
  output logic [num_req_p-1:0]             grant_o,
  output logic [id_width(num_req_p)-1:0]   grant_id_o,
  output logic                             grant_v_o
);

  localparam int id_w = id_width(num_req_p);

  logic [id_w-1:0] ptr_r;
  logic [id_w-1:0] idx;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    grant_v_o  = 1'b0;
    idx        = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      idx = id_w'((int'(ptr_r) + i) % num_req_p);
      if (!grant_v_o && v_i[idx]) begin
        grant_v_o    = 1'b1;
        grant_id_o   = idx;
        grant_o[idx] = 1'b1;
      end
    end
    if (rst_i) begin
      grant_o   = '0;
      grant_v_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      ptr_r <= id_w'(num_req_p - 1);
    else if (yumi_i)
      ptr_r <= grant_id_o;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin shared write port into a dff register bank.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int                 width_p     = 32,
  parameter int                 els_p       = 8,
  parameter int                 num_req_p   = 2,
  parameter logic [width_p-1:0] reset_val_p = '0,
  localparam int                addr_w      = $clog2(els_p),
  localparam int                id_w        = id_width(num_req_p)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  reg_write_arbiter_if.slave  bus,
  input  logic [addr_w-1:0]   r_addr_i,
  output logic [width_p-1:0]  r_data_o,
  output logic                grant_v_o,
  output logic [id_w-1:0]     grant_id_o,
  output logic                err_o
);

  logic [num_req_p-1:0] grant;
  logic [addr_w-1:0]    w_addr;
  logic [width_p-1:0]   w_data;
  logic                 in_range;
  logic [els_p-1:0]     w_en;
  logic [width_p-1:0]   regs [els_p];

  rr_arb #(.num_req_p(num_req_p)) u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .v_i        (bus.req_v_i),
    .yumi_i     (grant_v_o),
    .grant_o    (grant),
    .grant_id_o (grant_id_o),
    .grant_v_o  (grant_v_o)
  );

  assign bus.req_ready_o = grant;

  assign w_addr   = bus.req_addr_i[int'(grant_id_o)*addr_w +: addr_w];
  assign w_data   = bus.req_data_i[int'(grant_id_o)*width_p +: width_p];
  assign in_range = int'(w_addr) < els_p;

  for (genvar i = 0; i < els_p; i++) begin : g_bank
    assign w_en[i] = grant_v_o & in_range & (w_addr == addr_w'(i));
    dff #(
      .width_p     (width_p),
      .reset_val_p (reset_val_p)
    ) u_reg (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .w_v_i  (w_en[i]),
      .data_i (w_data),
      .data_o (regs[i])
    );
  end

  // No bypass: a same-cycle read sees the pre-write value.
  always_comb begin
    r_data_o = '0;
    if (int'(r_addr_i) < els_p)
      r_data_o = regs[r_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      err_o <= 1'b0;
    else if (grant_v_o && !in_range)
      err_o <= 1'b1;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares a single write port into a bank of `els_p` enable-gated registers (built from the team's `dff` primitive) between `num_req_p` requesters.
- Arbitration is round-robin with a valid/ready handshake; at most one write commits per cycle.
- One combinational read port exposes the bank.
- Sits between pipeline/peripheral agents (e.g. CPU writeback, VGA config writer) and a small shared register file or config bank.

Parameters:
- width_p, 32, data bits per register
- els_p, 8, number of registers (≥2, need not be a power of two)
- num_req_p, 2, number of requesters (≥2)
- reset_val_p, 0, value every register takes on reset
- addr_w (localparam), $clog2(els_p), register address width

Ports:
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  synchronous, active-high reset
- req_v_i  in  num_req_p  per-requester write request valid
- req_addr_i  in  num_req_p*addr_w  per-requester target address; slice k = requester k
- req_data_i  in  num_req_p*width_p  per-requester write data; slice k = requester k
- req_ready_o  out  num_req_p  one-hot (or zero) grant; write k commits when req_v_i[k] & req_ready_o[k]
- r_addr_i  in  addr_w  read address
- r_data_o  out  width_p  contents of register r_addr_i
- grant_v_o  out  1  a write commits this cycle
- grant_id_o  out  $clog2(num_req_p)  index of committing requester; valid when grant_v_o
- err_o  out  1  sticky: an accepted write targeted addr ≥ els_p

Behaviour:
- Clock and reset: one clock (clk_i). Reset is synchronous and active-high (rst_i); sampled only at posedge clk_i.
- Reset values:
  - all registers = reset_val_p
  - ptr_r = num_req_p-1, so requester 0 has top priority first
  - err_o = 0
- During any cycle with rst_i=1, req_ready_o is forced to 0 and grant_v_o to 0; no write commits.
- Arbitration (combinational from req_v_i and ptr_r):
  - Grant goes to the first k with req_v_i[k]=1, scanning ptr_r+1, ptr_r+2, … modulo num_req_p.
  - No valid requests → req_ready_o=0, grant_v_o=0.
- req_ready_o may depend combinationally on req_v_i. Requesters must not make req_v_i depend on req_ready_o.
- Pointer update: on a committing cycle, ptr_r <= granted index. Otherwise ptr_r holds.
- Wrap-around: after index num_req_p-1 is granted, index 0 has top priority.
- Write commit:
  - The granted requester's data is written to register addr on the next posedge; only that register's dff w_v_i is asserted.
  - Write-to-read latency is 1 cycle.
- Read:
  - r_data_o reflects current register contents combinationally; no write-through bypass.
  - A same-cycle read of the address being written returns the old value.
  - r_addr_i ≥ els_p → r_data_o = 0.
- Out-of-range write (addr ≥ els_p):
  - Handshake still completes and the pointer advances.
  - No register changes.
  - err_o sets the next cycle and stays set until reset.
- Non-granted requesters hold req_v_i/addr/data until accepted. The block keeps no queue.
- Back-to-back: one requester holding valid alone is granted every cycle (throughput 1 write/cycle).
- Fairness: with all requesters valid continuously, each is granted exactly once per num_req_p cycles.
- Reset asserted mid-stream: a write presented in the reset cycle is lost (ready=0). Arbitration restarts from requester 0 on the first cycle after reset.

Decomposition:
- No shared-package typedefs needed. addr_w and the grant-id width are local parameters derived with $clog2.
- Sub-module rr_arb (parameter num_req_p):
  - ports clk_i, rst_i, v_i, yumi_i, grant_o, grant_id_o, grant_v_o
  - holds ptr_r; advances the pointer on yumi_i
- The register bank is a generate loop of dff instances (width_p, reset_val_p), each with a decoded w_v_i.
- Read mux and error flop live in the top level.

Test Plan:
1. Reset with width_p=32, els_p=8, reset_val_p=0x5A → every r_addr_i 0..7 reads 0x5A; req_ready_o=0 and err_o=0 during reset.
2. Only requester 1 valid, addr=3, data=0xDEADBEEF → ready[1]=1 the same cycle; r_data_o at addr 3 shows 0xDEADBEEF from the next cycle; a same-cycle read shows the old value.
3. Both requesters valid continuously, addr 0 and 1, with incrementing data → grants alternate 0,1,0,1 starting with 0; each register holds its requester's latest accepted data.
4. Requester 0 valid alone for 3 cycles, then requester 1 joins → grants 0,0,0,1,0,1 (pointer honoured across idle/solo cycles).
5. els_p=6, write addr=7 → handshake completes; no register changes; err_o=1 next cycle and sticky until rst_i.
6. rst_i asserted for one cycle while both requesters are valid mid-stream → no commit that cycle, all registers return to reset_val_p, and requester 0 is granted first after reset.
